// File: rtl/lfsr_run_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// lfsr_run_ctrl_pkg
// Shared definitions for the LFSR run controller:
//   - default generator length, taken from the global length define
//   - run-controller state encodings
//   - helper returning the LFSR period (2^len - 1 symbols)
// ----------------------------------------------------------------------------
`ifndef LFSR_GLOBAL_LEN
`define LFSR_GLOBAL_LEN 22
`endif

package lfsr_run_ctrl_pkg;

   localparam int LFSR_LEN_DEF = `LFSR_GLOBAL_LEN;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] S_FLUSH = 3'd1;
   localparam logic [STATE_W-1:0] S_RUN   = 3'd2;
   localparam logic [STATE_W-1:0] S_DRAIN = 3'd3;
   localparam logic [STATE_W-1:0] S_DONE  = 3'd4;

   // Number of symbols in one maximal-length period.
   function automatic longint unsigned lfsr_period(input int len);
      return (64'd1 << len) - 64'd1;
   endfunction

endpackage

// File: rtl/lfsr_sym_tick.sv
// ----------------------------------------------------------------------------
// lfsr_sym_tick
// Symbol-rate tick generator. While 'run' is high a phase counter cycles
// 0..SPS-1 and an enable is issued in every clock where phase == SPS-1.
// A symbol counter counts those enables modulo the LFSR period and flags
// the enable that completes a period.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-high
//   clear       in   zero the symbol counter (run restart)
//   run         in   advance phase / issue enables
//   lfsr_clk_en out  registered symbol-rate enable
//   pce         out  registered, high with the period-completing enable
// ----------------------------------------------------------------------------
module lfsr_sym_tick
   import lfsr_run_ctrl_pkg::*;
#(
   parameter int LFSR_LEN = LFSR_LEN_DEF,
   parameter int SPS      = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic lfsr_clk_en,
   output logic pce
);

   localparam int PH_W = $clog2(SPS);

   localparam logic [PH_W-1:0]     PH_LAST  = PH_W'(SPS - 1);
   localparam logic [PH_W-1:0]     PH_PRE   = PH_W'(SPS - 2);
   localparam logic [LFSR_LEN-1:0] SYM_LAST = LFSR_LEN'(lfsr_period(LFSR_LEN) - 64'd1);

   logic [PH_W-1:0]     phase;
   logic [LFSR_LEN-1:0] sym_cnt;

   // The enable and period flag are decided one clock early (phase == SPS-2)
   // so that the registered outputs are high exactly while phase == SPS-1.
   // Dropping 'run' kills any enable decision immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase       <= '0;
         sym_cnt     <= '0;
         lfsr_clk_en <= 1'b0;
         pce         <= 1'b0;
      end else begin
         if (run) begin
            phase       <= (phase == PH_LAST) ? '0 : phase + 1'b1;
            lfsr_clk_en <= (phase == PH_PRE);
            pce         <= (phase == PH_PRE) && (sym_cnt == SYM_LAST);
            if (phase == PH_PRE) begin
               sym_cnt <= (sym_cnt == SYM_LAST) ? '0 : sym_cnt + 1'b1;
            end
         end else begin
            phase       <= '0;
            lfsr_clk_en <= 1'b0;
            pce         <= 1'b0;
         end
         if (clear) begin
            sym_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/lfsr_run_ctrl.sv
// ----------------------------------------------------------------------------
// lfsr_run_ctrl
// Sequences one measurement run of the LFSR symbol generator:
// restart + accumulator clear, symbol-rate enables, counting of complete
// LFSR periods with an accumulator dump per period, drain, and completion.
// Also checks the generator period marker against its own period count.
//
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   start         run request (IDLE only)
//   abort         terminate run immediately
//   num_periods   periods per run, 0 = continuous
//   cycle_in      period marker from the generator
//   lfsr_clk_en   symbol-rate enable to generator
//   lfsr_rst      restart pulse to generator
//   acc_clear     accumulator clear pulse
//   acc_dump      accumulator dump pulse per completed period
//   busy          high outside IDLE
//   done          normal completion pulse
//   aborted       abort completion pulse
//   periods_done  completed periods in current/last run (saturating)
//   sync_err      sticky marker-mismatch flag
// ----------------------------------------------------------------------------
module lfsr_run_ctrl
   import lfsr_run_ctrl_pkg::*;
#(
   parameter int LFSR_LEN  = LFSR_LEN_DEF,
   parameter int SPS       = 4,
   parameter int CYC_W     = 8,
   parameter int DRAIN_LAT = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [CYC_W-1:0] num_periods,
   input  logic             cycle_in,
   output logic             lfsr_clk_en,
   output logic             lfsr_rst,
   output logic             acc_clear,
   output logic             acc_dump,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [CYC_W-1:0] periods_done,
   output logic             sync_err
);

   localparam int DR_W  = (DRAIN_LAT > 1) ? $clog2(DRAIN_LAT) : 1;
   localparam int WIN_W = $clog2(SPS + 1);

   localparam logic [DR_W-1:0]  DR_LAST  = DR_W'(DRAIN_LAT - 1);
   localparam logic [WIN_W-1:0] WIN_FULL = WIN_W'(SPS);
   localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_nxt;
   logic               flush_second;
   logic [CYC_W-1:0]   np_q;
   logic [DR_W-1:0]    drain_cnt;
   logic [WIN_W-1:0]   win_left;
   logic               win_seen;

   logic               pce;
   logic               tick_run;
   logic               tick_clear;
   logic               abort_hit;
   logic               pce_ok;
   logic               start_run;
   logic               in_win;
   logic               last_period;
   logic [CYC_W-1:0]   pd_inc;

   // Abort must stop enables from the very next clock, so it gates the
   // tick generator combinationally.
   assign tick_run   = (state == S_RUN) && !abort;
   assign tick_clear = (state == S_FLUSH);

   lfsr_sym_tick #(
      .LFSR_LEN (LFSR_LEN),
      .SPS      (SPS)
   ) u_tick (
      .clk         (clk),
      .reset       (reset),
      .clear       (tick_clear),
      .run         (tick_run),
      .lfsr_clk_en (lfsr_clk_en),
      .pce         (pce)
   );

   // Abort wins over a coincident period completion: that period is
   // neither counted nor dumped.
   assign abort_hit   = abort && (state != S_IDLE);
   assign pce_ok      = pce && (state == S_RUN) && !abort_hit;
   assign start_run   = (state == S_IDLE) && start;
   assign in_win      = (win_left != '0);
   assign pd_inc      = (periods_done == {CYC_W{1'b1}}) ? periods_done
                                                        : periods_done + 1'b1;
   assign last_period = (np_q != '0) && (pd_inc == np_q);

   // Next-state selection; abort returns to IDLE from any active state.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            if (abort)             state_nxt = S_IDLE;
            else if (flush_second) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (abort)                    state_nxt = S_IDLE;
            else if (pce && last_period)  state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (abort)                       state_nxt = S_IDLE;
            else if (drain_cnt == DR_LAST)   state_nxt = S_DONE;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State, control pulses and run bookkeeping. Pulse outputs are derived
   // from the transition being taken so they line up with the new state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         flush_second <= 1'b0;
         np_q         <= '0;
         drain_cnt    <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         aborted      <= 1'b0;
         lfsr_rst     <= 1'b0;
         acc_clear    <= 1'b0;
         acc_dump     <= 1'b0;
         periods_done <= '0;
      end else begin
         state        <= state_nxt;
         busy         <= (state_nxt != S_IDLE);
         done         <= (state_nxt == S_DONE);
         aborted      <= abort_hit;
         lfsr_rst     <= start_run;
         acc_clear    <= start_run;
         acc_dump     <= pce_ok;
         flush_second <= (state == S_FLUSH);
         drain_cnt    <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
         if ((state == S_FLUSH) && (state_nxt == S_RUN)) begin
            np_q <= num_periods;
         end
         if (start_run) begin
            periods_done <= '0;
         end else if (pce_ok) begin
            periods_done <= pd_inc;
         end
      end
   end

   // Marker check: after each counted period completion a window of SPS
   // clocks opens; exactly one marker is expected inside, none outside.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win_left <= '0;
         win_seen <= 1'b0;
         sync_err <= 1'b0;
      end else begin
         if (start_run) begin
            sync_err <= 1'b0;
         end
         if (state == S_RUN) begin
            if (cycle_in && !in_win) begin
               sync_err <= 1'b1;
            end
            if (in_win) begin
               win_left <= win_left - 1'b1;
               win_seen <= win_seen | cycle_in;
               if ((win_left == WIN_ONE) && !win_seen && !cycle_in) begin
                  sync_err <= 1'b1;
               end
            end
            if (pce_ok) begin
               win_left <= WIN_FULL;
               win_seen <= 1'b0;
            end
         end else begin
            win_left <= '0;
            win_seen <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lfsr_run_ctrl
// Self-checking bench for lfsr_run_ctrl with LFSR_LEN=5 (P=31), SPS=4.
// A behavioural model predicts every output from elapsed time in each phase
// of the run; a small generator model answers enables with period markers.
// ----------------------------------------------------------------------------
module tb_lfsr_run_ctrl;

   localparam int LFSR_LEN  = 5;
   localparam int SPS       = 4;
   localparam int CYC_W     = 8;
   localparam int DRAIN_LAT = 3;
   localparam int P         = (1 << LFSR_LEN) - 1;
   localparam int PER       = P * SPS;
   localparam int PD_MAX    = (1 << CYC_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [CYC_W-1:0] num_periods = '0;
   logic             cycle_in = 1'b0;
   logic             lfsr_clk_en;
   logic             lfsr_rst;
   logic             acc_clear;
   logic             acc_dump;
   logic             busy;
   logic             done;
   logic             aborted;
   logic [CYC_W-1:0] periods_done;
   logic             sync_err;

   always #5 clk = ~clk;

   lfsr_run_ctrl #(
      .LFSR_LEN  (LFSR_LEN),
      .SPS       (SPS),
      .CYC_W     (CYC_W),
      .DRAIN_LAT (DRAIN_LAT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .abort        (abort),
      .num_periods  (num_periods),
      .cycle_in     (cycle_in),
      .lfsr_clk_en  (lfsr_clk_en),
      .lfsr_rst     (lfsr_rst),
      .acc_clear    (acc_clear),
      .acc_dump     (acc_dump),
      .busy         (busy),
      .done         (done),
      .aborted      (aborted),
      .periods_done (periods_done),
      .sync_err     (sync_err)
   );

   // ---------------- behavioural model ----------------
   typedef enum int {M_IDLE, M_FLUSH, M_RUN, M_DRAIN, M_DONE} mode_t;

   mode_t m_mode = M_IDLE;
   int    m_t    = 0;
   int    m_np   = 0;
   int    m_pd   = 0;
   bit    m_err  = 1'b0;
   bit    m_seen = 1'b0;
   bit    e_en = 0, e_rst = 0, e_clr = 0, e_dump = 0;
   bit    e_busy = 0, e_done = 0, e_abt = 0;

   // Model: enables fall every SPS clocks of RUN time, a period is P
   // enables, and each phase of the run lasts a fixed number of clocks.
   always @(posedge clk or posedge reset) begin
      bit en_c, pce_c, ab, pce_ok, in_win;
      int u;
      if (reset) begin
         m_mode = M_IDLE; m_t = 0; m_np = 0; m_pd = 0; m_err = 0; m_seen = 0;
         e_en = 0; e_rst = 0; e_clr = 0; e_dump = 0;
         e_busy = 0; e_done = 0; e_abt = 0;
      end else begin
         en_c   = (m_mode == M_RUN) && ((m_t % SPS) == SPS - 1);
         pce_c  = en_c && ((((m_t + 1) / SPS) % P) == 0);
         ab     = abort && (m_mode != M_IDLE);
         pce_ok = pce_c && !ab;
         if (m_mode == M_RUN) begin
            u      = (m_t + 1) % PER;
            in_win = ((m_t + 1) > PER) && (u >= 1) && (u <= SPS);
            if (cycle_in && !in_win) m_err = 1;
            if (in_win) begin
               if (u == 1) m_seen = 0;
               if (cycle_in) m_seen = 1;
               if ((u == SPS) && !m_seen) m_err = 1;
            end
         end
         if (pce_ok) m_pd = (m_pd == PD_MAX) ? PD_MAX : m_pd + 1;
         e_abt  = ab;
         e_dump = pce_ok;
         if (ab) begin
            m_mode = M_IDLE; m_t = 0;
         end else begin
            case (m_mode)
               M_IDLE:  if (start) begin
                           m_mode = M_FLUSH; m_t = 0; m_pd = 0; m_err = 0;
                        end
               M_FLUSH: if (m_t == 1) begin
                           m_mode = M_RUN; m_t = 0; m_np = int'(num_periods);
                        end else m_t++;
               M_RUN:   if (pce_ok && (m_np != 0) && (m_pd == m_np)) begin
                           m_mode = M_DRAIN; m_t = 0;
                        end else m_t++;
               M_DRAIN: if (m_t == DRAIN_LAT - 1) begin
                           m_mode = M_DONE; m_t = 0;
                        end else m_t++;
               default: begin m_mode = M_IDLE; m_t = 0; end
            endcase
         end
         e_busy = (m_mode != M_IDLE);
         e_done = (m_mode == M_DONE);
         e_rst  = (m_mode == M_FLUSH) && (m_t == 0);
         e_clr  = e_rst;
         e_en   = (m_mode == M_RUN) && ((m_t % SPS) == SPS - 1);
      end
   end

   // ---------------- checking / stimulus ----------------
   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int n_en = 0, n_dump = 0, n_done = 0, n_abt = 0, n_rst = 0;
   int first_en_cyc = -1;
   int last_done_cyc = -1;
   bit err_at_done = 1'b0;
   int gen_cnt = 0;
   int mk_delay = 0;
   bit late_mode = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic failTimeout(input string name);
      n_checks++;
      n_errors++;
      $display("[TB] FAIL %s: timed out, got no event, expected event", name);
   endtask

   task automatic applyStimulus(input bit s, input bit a, input int np);
      start       = s;
      abort       = a;
      num_periods = CYC_W'(np);
   endtask

   // One clock: compare against the model, count pulses, and play the
   // generator (marker in the clock after its P-th enable, or SPS later).
   task automatic tick();
      @(negedge clk);
      cyc++;
      checkOutput($sformatf("cyc%0d lfsr_clk_en", cyc), lfsr_clk_en, e_en);
      checkOutput($sformatf("cyc%0d lfsr_rst", cyc), lfsr_rst, e_rst);
      checkOutput($sformatf("cyc%0d acc_clear", cyc), acc_clear, e_clr);
      checkOutput($sformatf("cyc%0d acc_dump", cyc), acc_dump, e_dump);
      checkOutput($sformatf("cyc%0d busy", cyc), busy, e_busy);
      checkOutput($sformatf("cyc%0d done", cyc), done, e_done);
      checkOutput($sformatf("cyc%0d aborted", cyc), aborted, e_abt);
      checkOutput($sformatf("cyc%0d periods_done", cyc), periods_done, m_pd);
      checkOutput($sformatf("cyc%0d sync_err", cyc), sync_err, m_err);
      if (lfsr_clk_en === 1'b1) begin
         n_en++;
         if (first_en_cyc < 0) first_en_cyc = cyc;
      end
      if (acc_dump === 1'b1) n_dump++;
      if (aborted === 1'b1)  n_abt++;
      if (lfsr_rst === 1'b1) n_rst++;
      if (done === 1'b1) begin
         n_done++;
         last_done_cyc = cyc;
         err_at_done = sync_err;
      end
      cycle_in = 1'b0;
      if (mk_delay > 0) begin
         mk_delay--;
         if (mk_delay == 0) cycle_in = 1'b1;
      end
      if (lfsr_rst === 1'b1) begin
         gen_cnt  = 0;
         mk_delay = 0;
      end else if (lfsr_clk_en === 1'b1) begin
         gen_cnt++;
         if (gen_cnt == P) begin
            gen_cnt  = 0;
            mk_delay = late_mode ? SPS + 1 : 1;
         end
      end
   endtask

   task automatic startRun(input int np, output int s);
      applyStimulus(1, 0, np);
      s = cyc;
      tick();
      applyStimulus(0, 0, np);
   endtask

   task automatic waitRun(input int target);
      int guard = 0;
      while (!((m_mode == M_RUN) && (m_t == target)) && (guard < 5000)) begin
         tick();
         guard++;
      end
      if (guard >= 5000) failTimeout($sformatf("waitRun t=%0d", target));
   endtask

   task automatic waitIdle(input int limit);
      int guard = 0;
      while ((busy !== 1'b0) && (guard < limit)) begin
         tick();
         guard++;
      end
      if (guard >= limit) failTimeout("waitIdle");
   endtask

   initial begin
      int s;
      int b_en, b_dump, b_done, b_abt, b_rst;

      // Reset state
      applyStimulus(0, 0, 0);
      tick();
      tick();
      checkOutput("reset busy", busy, 0);
      checkOutput("reset periods_done", periods_done, 0);
      checkOutput("reset lfsr_clk_en", lfsr_clk_en, 0);
      reset = 1'b0;
      tick();

      // 1: two-period run; num_periods changed mid-run must not matter
      $display("[TB] test 1: two-period run");
      b_en = n_en; b_dump = n_dump; b_done = n_done; b_rst = n_rst; b_abt = n_abt;
      first_en_cyc = -1;
      startRun(2, s);
      waitRun(0);
      applyStimulus(0, 0, 1);
      waitIdle(600);
      checkOutput("t1 enables", n_en - b_en, 62);
      checkOutput("t1 dumps", n_dump - b_dump, 2);
      checkOutput("t1 done pulses", n_done - b_done, 1);
      checkOutput("t1 lfsr_rst pulses", n_rst - b_rst, 1);
      checkOutput("t1 aborted pulses", n_abt - b_abt, 0);
      checkOutput("t1 periods_done", periods_done, 2);
      checkOutput("t1 first enable offset", first_en_cyc - s, 6);
      checkOutput("t1 done offset", last_done_cyc - s, 254);
      applyStimulus(0, 1, 2);
      tick();
      applyStimulus(0, 0, 2);
      tick();
      checkOutput("idle abort ignored", n_abt - b_abt, 0);

      // 2: abort 20 clocks into RUN
      $display("[TB] test 2: abort mid-run");
      b_en = n_en; b_done = n_done; b_abt = n_abt;
      startRun(2, s);
      waitRun(20);
      applyStimulus(0, 1, 2);
      tick();
      applyStimulus(0, 0, 2);
      waitIdle(10);
      b_en = n_en;
      repeat (8) tick();
      checkOutput("t2 enables after abort", n_en - b_en, 0);
      checkOutput("t2 aborted pulses", n_abt - b_abt, 1);
      checkOutput("t2 done pulses", n_done - b_done, 0);
      checkOutput("t2 periods_done", periods_done, 0);
      checkOutput("t2 busy", busy, 0);

      // 3: abort coincident with first period completion
      $display("[TB] test 3: abort at first PCE");
      b_en = n_en; b_dump = n_dump; b_abt = n_abt;
      startRun(2, s);
      waitRun(PER - 1);
      applyStimulus(0, 1, 2);
      tick();
      applyStimulus(0, 0, 2);
      waitIdle(10);
      repeat (3) tick();
      checkOutput("t3 enables", n_en - b_en, 31);
      checkOutput("t3 dumps", n_dump - b_dump, 0);
      checkOutput("t3 aborted pulses", n_abt - b_abt, 1);
      checkOutput("t3 periods_done", periods_done, 0);

      // 4: continuous mode, five periods, then abort
      $display("[TB] test 4: continuous mode");
      b_dump = n_dump; b_done = n_done; b_abt = n_abt;
      startRun(0, s);
      waitRun(5 * PER + 10);
      applyStimulus(0, 1, 0);
      tick();
      applyStimulus(0, 0, 0);
      waitIdle(10);
      checkOutput("t4 periods_done", periods_done, 5);
      checkOutput("t4 dumps", n_dump - b_dump, 5);
      checkOutput("t4 done pulses", n_done - b_done, 0);
      checkOutput("t4 aborted pulses", n_abt - b_abt, 1);
      checkOutput("t4 sync_err", sync_err, 0);

      // 5: late marker sets sync_err; cleared by next start
      $display("[TB] test 5: marker alignment");
      late_mode = 1'b1;
      startRun(2, s);
      waitIdle(600);
      checkOutput("t5 sync_err at done", err_at_done, 1);
      tick();
      checkOutput("t5 sync_err held", sync_err, 1);
      late_mode = 1'b0;
      startRun(2, s);
      tick();
      checkOutput("t5 sync_err cleared", sync_err, 0);
      waitIdle(600);
      checkOutput("t5 aligned sync_err at done", err_at_done, 0);
      checkOutput("t5 aligned periods_done", periods_done, 2);

      // 6: reset mid-run, start while busy, then clean run
      $display("[TB] test 6: reset mid-run");
      startRun(2, s);
      waitRun(50);
      applyStimulus(1, 0, 2);
      tick();
      applyStimulus(0, 0, 2);
      tick();
      #3 reset = 1'b1;
      #1;
      checkOutput("t6 reset busy", busy, 0);
      checkOutput("t6 reset lfsr_clk_en", lfsr_clk_en, 0);
      checkOutput("t6 reset acc_dump", acc_dump, 0);
      checkOutput("t6 reset periods_done", periods_done, 0);
      checkOutput("t6 reset sync_err", sync_err, 0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      b_done = n_done;
      startRun(1, s);
      waitIdle(400);
      checkOutput("t6 clean periods_done", periods_done, 1);
      checkOutput("t6 clean done pulses", n_done - b_done, 1);
      checkOutput("t6 clean done offset", last_done_cyc - s, 130);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lfsr_run_ctrl.md
Name: lfsr_run_ctrl

Overview:
Run controller for the maximal-length LFSR symbol generator. It sequences one measurement run: generator restart, accumulator clear, symbol-rate clock enables at one enable per SPS clocks, and counting of complete LFSR periods. At each period boundary it strobes the reference-level accumulator dump. It checks the generator's period marker against its own period count and sits between the top-level control registers and the generator/accumulator pair.

Parameters:
LFSR_LEN, 22, generator length; period P = 2^LFSR_LEN - 1 symbols
SPS, 4, clocks per symbol (>=2)
CYC_W, 8, width of run-length and period counters
DRAIN_LAT, 3, clocks waited after the last period before done

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
start  in  1  run request, sampled in IDLE only
abort  in  1  terminate run immediately
num_periods  in  CYC_W  periods per run; 0 = continuous until abort
cycle_in  in  1  period marker from generator
lfsr_clk_en  out  1  symbol-rate enable to generator
lfsr_rst  out  1  one-clock synchronous restart pulse to generator
acc_clear  out  1  accumulator clear pulse
acc_dump  out  1  accumulator dump pulse, one per completed period
busy  out  1  high in every state except IDLE
done  out  1  one-clock pulse at normal completion
aborted  out  1  one-clock pulse when abort ends a run
periods_done  out  CYC_W  completed periods in current/last run
sync_err  out  1  sticky marker-mismatch flag

Behaviour:
- All outputs registered. On reset: state IDLE, all outputs 0, all counters 0.
- States: IDLE, FLUSH, RUN, DRAIN, DONE.
- IDLE: start=1 -> FLUSH. On entry to FLUSH: periods_done=0, sync_err=0. start outside IDLE is ignored.
- FLUSH: 2 clocks. First clock: lfsr_rst=1 and acc_clear=1. Second clock: both 0. Then RUN with phase=0, sym_cnt=0.
- RUN: phase counts 0..SPS-1 and wraps. lfsr_clk_en=1 exactly in clocks where phase==SPS-1, so the first enable comes SPS clocks after RUN entry.
- sym_cnt (LFSR_LEN bits) increments on each enable. It wraps from P-1 to 0 on the period-completing enable (PCE).
- On PCE: periods_done increments, saturating at all-ones. acc_dump=1 in the following clock.
- If num_periods!=0 and the incremented periods_done equals num_periods, the next state is DRAIN. No further lfsr_clk_en is issued.
- num_periods is sampled only at the FLUSH->RUN transition. Later changes have no effect until the next run.
- DRAIN: DRAIN_LAT clocks with no enables, then DONE.
- DONE: done=1 for one clock, then IDLE. periods_done holds its value until the next start.
- abort=1 in FLUSH/RUN/DRAIN/DONE: next state IDLE, aborted=1 for one clock, lfsr_clk_en=0 from the next clock, and done is not asserted. abort has priority over a simultaneous PCE; that period is not counted and acc_dump is not issued. abort in IDLE is ignored.
- Sync check, active in RUN only. The expected window is the SPS clocks starting the clock after a PCE. cycle_in=1 outside a window sets sync_err. No cycle_in within a window also sets sync_err. sync_err holds until the next FLUSH entry.
- Continuous mode (num_periods=0): RUN never exits except by abort. periods_done saturates.

Decomposition:
- Shared defines: state encodings, LFSR period constant derived from LFSR_LEN; LFSR_LEN taken from the existing global length define.
- Sub-module lfsr_sym_tick: the phase counter plus sym_cnt, producing lfsr_clk_en and pce. Everything else (FSM, period counting, sync check) stays in lfsr_run_ctrl.

Test Plan:
1. LFSR_LEN=5, SPS=4, num_periods=2, start pulse -> lfsr_rst/acc_clear high 1 clock; first lfsr_clk_en 4 clocks after RUN entry; 62 enables total; acc_dump after enables 31 and 62; done 3+1 clocks after last PCE; periods_done=2.
2. Same config, abort 20 clocks into RUN -> aborted pulse, lfsr_clk_en 0 from next clock, no done, busy low, periods_done=0.
3. Abort in the same clock as the first PCE -> periods_done stays 0, no acc_dump, aborted=1.
4. num_periods=0, run 5 periods, then abort -> periods_done=5, 5 acc_dump pulses, done never asserted.
5. Drive cycle_in 1 symbol late relative to the expected window -> sync_err set and held through DONE; cleared on next start; aligned cycle_in keeps sync_err=0.
6. Assert reset mid-RUN -> all outputs 0 immediately, state IDLE; start ignored while busy; subsequent clean run completes normally.
